i2c_eeprom_slave: RTL
=====================

I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 128, number of 8-bit memory locations (7-bit address space).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on rising edge; one clock only.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port scl, input, 1, bus clock from initiator, asynchronous to clk.
REQ-005 SHALL have port sda, inout, 1, bus data; block drives only 0 or Z.
REQ-006 SHALL have port busy, output, 1, high from START detect until return to IDLE.
REQ-007 SHALL have port wr_strobe, output, 1, one-clk pulse when a data byte is committed to memory.
REQ-008 SHALL have port rd_strobe, output, 1, one-clk pulse when a read byte has been fully shifted out.
REQ-009 SHALL have port last_addr, output, 7, memory address of the last completed transaction.
REQ-010 SHALL have port last_data, output, 8, data byte of the last completed transaction.

Function
REQ-011 SHALL pass scl and sda through 2-flop synchronizers; all bus events SHALL be detected on synchronized values (detection latency 3 clk max).
REQ-012 SHALL detect START as sda 1->0 while scl high, and STOP as sda 0->1 while scl high.
REQ-013 SHALL sample sda on scl rising edges and change driven sda only on the clk after a scl falling edge.
REQ-014 SHALL receive the header byte LSB first: bit0 = mode (1 = write, 0 = read), bits 1-7 = memory address bits 0-6.
REQ-015 SHALL receive and transmit data bytes LSB first.
REQ-016 SHALL implement states IDLE, HDR, HDR_ACK, WDATA, WDATA_ACK, RDATA, WAIT_STOP.
REQ-017 IDLE: sda released; START -> HDR with bit counter = 0.
REQ-018 HDR: after 8th scl rise -> HDR_ACK.
REQ-019 HDR_ACK: drive sda=0 from the next scl fall until the following scl fall, then -> WDATA if mode=1, else -> RDATA.
REQ-020 WDATA: after 8th scl rise, write mem[addr] in the next clk, pulse wr_strobe, update last_addr/last_data, -> WDATA_ACK.
REQ-021 WDATA_ACK: ACK as in REQ-019, then -> WAIT_STOP.
REQ-022 RDATA: load shift register from mem[addr] on HDR_ACK exit, drive bit0 at that scl fall, then drive one bit per scl fall.
REQ-023 RDATA exit: on the scl fall after the 8th bit, release sda, pulse rd_strobe, update last_addr/last_data, -> WAIT_STOP.
REQ-024 Each transaction SHALL be single-byte; WAIT_STOP ignores scl and keeps sda released.
REQ-025 STOP in any state SHALL go to IDLE; a partially received write byte SHALL NOT be written.
REQ-026 START in any non-IDLE state (repeated start) SHALL go to HDR with the counter cleared and sda released.
REQ-027 When address >= MEM_DEPTH, the block SHALL NACK the header (sda released in the ACK slot) and go to WAIT_STOP.
REQ-028 Memory contents SHALL NOT be cleared by reset and SHALL be undefined until written.

Reset
REQ-029 With rst low, the block SHALL be in IDLE and sda SHALL be Z within the same cycle (asynchronous).
REQ-030 Reset values SHALL be: busy=0, wr_strobe=0, rd_strobe=0, last_addr=0, last_data=0, counters=0, synchronizer flops=1.
REQ-031 Reset asserted mid-transfer SHALL abort without a memory write, and the block SHALL then wait for a fresh START.

Configuration
REQ-032 With macro I2C_SLAVE_WPROT_EN defined, the block SHALL add input wp (1 bit); while wp=1 in WDATA, the memory write and wr_strobe SHALL be suppressed and the data byte SHALL be NACKed.
REQ-033 Without I2C_SLAVE_WPROT_EN, port wp SHALL be absent and writes SHALL never be blocked.

Verification
REQ-034 Write then read: write 0xA5 to addr 0x12, then read addr 0x12 -> header and data ACKed, wr_strobe once, rd_strobe once, returned byte 0xA5, last_addr=0x12, last_data=0xA5.
REQ-035 Abort: STOP after 4 data bits of a write of 0x3C to addr 0x05 -> no wr_strobe, mem[0x05] unchanged, busy=0.
REQ-036 Repeated start: START during WDATA, then a read of addr 0x12 -> old contents 0xA5 returned, no spurious write.
REQ-037 Reset: rst low during RDATA bit 3 -> sda Z immediately; after release, the next full write of 0x77 to addr 0x01 succeeds.
REQ-038 Write protect: with I2C_SLAVE_WPROT_EN defined and wp=1, write 0xFF to addr 0x12 -> data NACKed, no wr_strobe, read returns 0xA5.
REQ-039 Out of range: with MEM_DEPTH=64, a header for addr 0x50 -> NACK, no strobes, IDLE after STOP.

Source files
------------

// File: rtl/i2c_eeprom_slave.sv
// Single-byte EEPROM-style bus target: LSB-first header {addr[6:0], mode}, one data byte per transaction.
// Define I2C_SLAVE_WPROT_EN to add the wp input that NACKs and suppresses writes.
module i2c_eeprom_slave #(
    parameter int MEM_DEPTH = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       wr_strobe,
    output logic       rd_strobe,
    output logic [6:0] last_addr,
    output logic [7:0] last_data
`ifdef I2C_SLAVE_WPROT_EN
    ,
    input  logic       wp
`endif
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, HDR, HDR_ACK, WDATA, WDATA_ACK, RDATA, WAIT_STOP
    } state_t;

    state_t      state_q;
    logic [1:0]  scl_s_q, sda_s_q;
    logic        scl_p_q, sda_p_q;
    logic [2:0]  cnt_q;
    logic [7:0]  sh_q;
    logic [6:0]  addr_q;
    logic        mode_q, nack_q, ack_ph_q, sda_oe_q;
    logic        wr_pend_q, wr_strobe_q, rd_strobe_q, busy_q;
    logic [6:0]  last_addr_q;
    logic [7:0]  last_data_q;
    logic [7:0]  mem [MEM_DEPTH];

    logic        scl_rise, scl_fall, start_det, stop_det, wp_blk;
    logic [7:0]  byte_d, mem_rd;

`ifdef I2C_SLAVE_WPROT_EN
    assign wp_blk = wp;
`else
    assign wp_blk = 1'b0;
`endif

    // Bus events are judged only on the synchronized copies and their one-clk history.
    assign scl_rise  =  scl_s_q[1] & ~scl_p_q;
    assign scl_fall  = ~scl_s_q[1] &  scl_p_q;
    assign start_det =  scl_s_q[1] &  scl_p_q &  sda_p_q & ~sda_s_q[1];
    assign stop_det  =  scl_s_q[1] &  scl_p_q & ~sda_p_q &  sda_s_q[1];
    assign byte_d    = {sda_s_q[1], sh_q[7:1]};
    assign mem_rd    = mem[addr_q[AW-1:0]];

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign rd_strobe = rd_strobe_q;
    assign last_addr = last_addr_q;
    assign last_data = last_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            scl_s_q     <= 2'b11;
            sda_s_q     <= 2'b11;
            scl_p_q     <= 1'b1;
            sda_p_q     <= 1'b1;
            cnt_q       <= 3'd0;
            sh_q        <= 8'd0;
            addr_q      <= 7'd0;
            mode_q      <= 1'b0;
            nack_q      <= 1'b0;
            ack_ph_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
            last_addr_q <= 7'd0;
            last_data_q <= 8'd0;
        end else begin
            scl_s_q     <= {scl_s_q[0], scl};
            sda_s_q     <= {sda_s_q[0], sda};
            scl_p_q     <= scl_s_q[1];
            sda_p_q     <= sda_s_q[1];
            wr_pend_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;

            // The byte is already complete when wr_pend_q is set, so it commits even if STOP follows.
            if (wr_pend_q) begin
                wr_strobe_q <= 1'b1;
                last_addr_q <= addr_q;
                last_data_q <= sh_q;
            end

            if (stop_det) begin
                state_q  <= IDLE;
                cnt_q    <= 3'd0;
                ack_ph_q <= 1'b0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (start_det) begin
                state_q  <= HDR;
                cnt_q    <= 3'd0;
                ack_ph_q <= 1'b0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    HDR: if (scl_rise) begin
                        sh_q  <= byte_d;
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q  <= HDR_ACK;
                            mode_q   <= byte_d[0];
                            addr_q   <= byte_d[7:1];
                            nack_q   <= ({25'd0, byte_d[7:1]} >= 32'(MEM_DEPTH));
                            ack_ph_q <= 1'b0;
                        end
                    end
                    HDR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!ack_ph_q) begin
                            ack_ph_q <= 1'b1;
                            sda_oe_q <= ~nack_q;
                        end else begin
                            ack_ph_q <= 1'b0;
                            sda_oe_q <= 1'b0;
                            cnt_q    <= 3'd0;
                            if (nack_q || state_q == WDATA_ACK) begin
                                state_q <= WAIT_STOP;
                            end else if (mode_q) begin
                                state_q <= WDATA;
                            end else begin
                                state_q  <= RDATA;
                                sh_q     <= mem_rd;
                                sda_oe_q <= ~mem_rd[0];
                            end
                        end
                    end
                    WDATA: if (scl_rise) begin
                        sh_q  <= byte_d;
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q   <= WDATA_ACK;
                            ack_ph_q  <= 1'b0;
                            nack_q    <= wp_blk;
                            wr_pend_q <= ~wp_blk;
                        end
                    end
                    // Rotating keeps the next bit in sh_q[1]; the eighth rotation restores the byte.
                    RDATA: if (scl_fall) begin
                        sh_q <= {sh_q[0], sh_q[7:1]};
                        if (cnt_q == 3'd7) begin
                            state_q     <= WAIT_STOP;
                            cnt_q       <= 3'd0;
                            sda_oe_q    <= 1'b0;
                            rd_strobe_q <= 1'b1;
                            last_addr_q <= addr_q;
                            last_data_q <= {sh_q[0], sh_q[7:1]};
                        end else begin
                            cnt_q    <= cnt_q + 3'd1;
                            sda_oe_q <= ~sh_q[1];
                        end
                    end
                    default: sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

    // Storage has no reset; contents persist across rst.
    always_ff @(posedge clk) begin
        if (wr_pend_q) mem[addr_q[AW-1:0]] <= sh_q;
    end

endmodule
